// File: rtl/trap_flow_ctrl_if.sv
// Pipeline/CSR <-> trap flow controller bundle.
// master = pipeline and CSR side, slave = trap_flow_ctrl.
interface trap_flow_ctrl_if #(
    parameter int unsigned CNT_W = 8
);
    localparam int unsigned XLEN = 32;

    logic            irq_timer;
    logic            mstatus_mie;
    logic            mie_mtie;
    logic [XLEN-1:0] mtvec;
    logic [XLEN-1:0] mepc;
    logic [XLEN-1:0] pc_de;
    logic            inst_valid_de;
    logic            br_take_de;
    logic [XLEN-1:0] br_target_de;
    logic            is_mret_mw;
    logic            inst_valid_mw;
    logic            stall_ext;

    logic             stall;
    logic             flush_de;
    logic             flush_mw;
    logic             redirect;
    logic [XLEN-1:0]  redirect_pc;
    logic             trap_take;
    logic [XLEN-1:0]  trap_epc;
    logic             in_handler;
    logic [CNT_W-1:0] trap_cnt;

    modport master (
        output irq_timer, mstatus_mie, mie_mtie, mtvec, mepc, pc_de,
               inst_valid_de, br_take_de, br_target_de, is_mret_mw,
               inst_valid_mw, stall_ext,
        input  stall, flush_de, flush_mw, redirect, redirect_pc,
               trap_take, trap_epc, in_handler, trap_cnt
    );

    modport slave (
        input  irq_timer, mstatus_mie, mie_mtie, mtvec, mepc, pc_de,
               inst_valid_de, br_take_de, br_target_de, is_mret_mw,
               inst_valid_mw, stall_ext,
        output stall, flush_de, flush_mw, redirect, redirect_pc,
               trap_take, trap_epc, in_handler, trap_cnt
    );
endinterface

// File: rtl/trap_flow_ctrl.sv
// Squash, stall and PC-redirect sequencer for the 3-stage RV32 core:
// branch squash, precise timer-interrupt entry and MRET return.
module trap_flow_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic          clk,
    input  logic          rst,
    trap_flow_ctrl_if.slave bus
);
    localparam int unsigned XLEN = 32;

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_e;

    state_e                 state_q;
    state_e                 state_d;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       cnt_q;

    logic            irq_ok;
    logic            mret_mw;
    logic            br_de;
    logic            stall;
    logic            flush_de;
    logic            flush_mw;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic            trap_take;
    logic [XLEN-1:0] trap_epc;

    assign irq_ok  = sync_q[SYNC_STAGES-1] & bus.mstatus_mie & bus.mie_mtie;
    assign mret_mw = bus.is_mret_mw & bus.inst_valid_mw;
    assign br_de   = bus.br_take_de & bus.inst_valid_de;

    // Control decisions; reset and external stall silence every pulse.
    always_comb begin
        state_d     = state_q;
        stall       = 1'b0;
        flush_de    = 1'b0;
        flush_mw    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        trap_take   = 1'b0;
        trap_epc    = '0;
        if (rst) begin
            state_d = RUN;
        end else if (bus.stall_ext) begin
            stall = 1'b1;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (irq_ok && bus.inst_valid_de && !mret_mw) begin
                        trap_take   = 1'b1;
                        trap_epc    = bus.pc_de;
                        redirect    = 1'b1;
                        redirect_pc = bus.mtvec;
                        flush_de    = 1'b1;
                        flush_mw    = 1'b1;
                        state_d     = HANDLER;
                    end else if (br_de) begin
                        redirect    = 1'b1;
                        redirect_pc = bus.br_target_de;
                        flush_de    = 1'b1;
                    end
                end
                HANDLER: begin
                    // MRET in MW outranks and squashes a branch in DE.
                    if (mret_mw) begin
                        redirect    = 1'b1;
                        redirect_pc = bus.mepc;
                        flush_de    = 1'b1;
                        flush_mw    = 1'b1;
                        state_d     = RUN;
                    end else if (br_de) begin
                        redirect    = 1'b1;
                        redirect_pc = bus.br_target_de;
                        flush_de    = 1'b1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            sync_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q   <= state_d;
            sync_q[0] <= bus.irq_timer;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            if (trap_take && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.stall       = stall;
    assign bus.flush_de    = flush_de;
    assign bus.flush_mw    = flush_mw;
    assign bus.redirect    = redirect;
    assign bus.redirect_pc = redirect_pc;
    assign bus.trap_take   = trap_take;
    assign bus.trap_epc    = trap_epc;
    assign bus.in_handler  = (state_q == HANDLER);
    assign bus.trap_cnt    = cnt_q;

    // An MRET retiring outside the handler means the pipeline is broken.
    mret_in_run_a: assert property (@(posedge clk) disable iff (rst)
        !(state_q == RUN && mret_mw));

endmodule
